// File: rtl/axis_frame_checker.sv
// AXI4-Stream acquisition frame checker: magic, timestamp, DATA_WORDS payload beats per frame.
// Define AXIS_FRAME_CHECKER_TLAST_CHECK_EN to enable tlast framing checks and the tlast_err counter.
module axis_frame_checker #(
    parameter int unsigned DATA_WORDS = 35,
    parameter logic [63:0] MAGIC      = 64'hDEADBEEFCAFEBABE,
    parameter logic [63:0] PATTERN    = 64'h123456789ABCDEF0,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [63:0]      s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic             s_axis_tlast,
    input  logic             clear_counters,
    output logic             locked,
    output logic             frame_done,
    output logic [63:0]      last_timestamp,
    output logic [CNT_W-1:0] frames_ok,
    output logic [CNT_W-1:0] sync_err,
    output logic [CNT_W-1:0] ts_err,
    output logic [CNT_W-1:0] data_err,
    output logic [CNT_W-1:0] tlast_err
);

    localparam logic [7:0] LastIdx = 8'(DATA_WORDS - 1);

    typedef enum logic [1:0] {StHunt, StTs, StData, StMagicChk} state_e;

    state_e      state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic        locked_q, locked_d;
    logic        ts_ref_valid_q, ts_ref_valid_d;
    logic        frame_err_q, frame_err_d;
    logic        frame_done_q, frame_done_d;
    logic [63:0] cur_ts_q, cur_ts_d;
    logic [63:0] last_ts_q, last_ts_d;
    logic        tready_q;

    logic [CNT_W-1:0] frames_ok_q, sync_err_q, ts_err_q, data_err_q;
    logic             inc_ok, inc_sync, inc_ts, inc_data, inc_tlast;

    logic beat;
    logic word_bad;
    logic tlast_bad;

    assign beat     = s_axis_tvalid && tready_q;
    assign word_bad = s_axis_tdata != PATTERN;

`ifdef AXIS_FRAME_CHECKER_TLAST_CHECK_EN
    // While aligned, tlast must coincide exactly with the final payload beat.
    assign tlast_bad = (state_q != StHunt) &&
                       (s_axis_tlast != ((state_q == StData) && (idx_q == LastIdx)));
`else
    assign tlast_bad = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        locked_d       = locked_q;
        ts_ref_valid_d = ts_ref_valid_q;
        frame_err_d    = frame_err_q;
        frame_done_d   = 1'b0;
        cur_ts_d       = cur_ts_q;
        last_ts_d      = last_ts_q;
        inc_ok         = 1'b0;
        inc_sync       = 1'b0;
        inc_ts         = 1'b0;
        inc_data       = 1'b0;
        inc_tlast      = 1'b0;

        if (beat) begin
            if (tlast_bad) begin
                // A framing error aborts the frame; the offending beat is consumed unchecked.
                inc_tlast = 1'b1;
                locked_d  = 1'b0;
                state_d   = StHunt;
            end else begin
                unique case (state_q)
                    StHunt: begin
                        if (s_axis_tdata == MAGIC) begin
                            state_d  = StTs;
                            locked_d = 1'b1;
                        end
                    end
                    StTs: begin
                        cur_ts_d    = s_axis_tdata;
                        idx_d       = 8'd0;
                        frame_err_d = 1'b0;
                        state_d     = StData;
                        if (ts_ref_valid_q && (s_axis_tdata != last_ts_q + 64'd1)) begin
                            inc_ts      = 1'b1;
                            frame_err_d = 1'b1;
                        end
                    end
                    StData: begin
                        inc_data = word_bad;
                        idx_d    = idx_q + 8'd1;
                        if (idx_q == LastIdx) begin
                            frame_done_d   = 1'b1;
                            last_ts_d      = cur_ts_q;
                            ts_ref_valid_d = 1'b1;
                            inc_ok         = !(frame_err_q || word_bad);
                            state_d        = StMagicChk;
                        end else if (word_bad) begin
                            frame_err_d = 1'b1;
                        end
                    end
                    StMagicChk: begin
                        if (s_axis_tdata == MAGIC) begin
                            state_d = StTs;
                        end else begin
                            inc_sync = 1'b1;
                            locked_d = 1'b0;
                            state_d  = StHunt;
                        end
                    end
                endcase
            end
            if (!locked_d) begin
                ts_ref_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StHunt;
            idx_q          <= 8'd0;
            locked_q       <= 1'b0;
            ts_ref_valid_q <= 1'b0;
            frame_err_q    <= 1'b0;
            frame_done_q   <= 1'b0;
            cur_ts_q       <= 64'd0;
            last_ts_q      <= 64'd0;
            tready_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            locked_q       <= locked_d;
            ts_ref_valid_q <= ts_ref_valid_d;
            frame_err_q    <= frame_err_d;
            frame_done_q   <= frame_done_d;
            cur_ts_q       <= cur_ts_d;
            last_ts_q      <= last_ts_d;
            tready_q       <= 1'b1;
        end
    end

    // Saturating counters; clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || clear_counters) begin
            frames_ok_q <= '0;
            sync_err_q  <= '0;
            ts_err_q    <= '0;
            data_err_q  <= '0;
        end else begin
            if (inc_ok && (frames_ok_q != '1)) frames_ok_q <= frames_ok_q + CNT_W'(1);
            if (inc_sync && (sync_err_q != '1)) sync_err_q <= sync_err_q + CNT_W'(1);
            if (inc_ts && (ts_err_q != '1)) ts_err_q <= ts_err_q + CNT_W'(1);
            if (inc_data && (data_err_q != '1)) data_err_q <= data_err_q + CNT_W'(1);
        end
    end

`ifdef AXIS_FRAME_CHECKER_TLAST_CHECK_EN
    logic [CNT_W-1:0] tlast_err_q;

    always_ff @(posedge clk) begin
        if (rst || clear_counters) begin
            tlast_err_q <= '0;
        end else if (inc_tlast && (tlast_err_q != '1)) begin
            tlast_err_q <= tlast_err_q + CNT_W'(1);
        end
    end

    assign tlast_err = tlast_err_q;
`else
    logic unused_tlast;
    assign unused_tlast = s_axis_tlast ^ inc_tlast;
    assign tlast_err    = '0;
`endif

    assign s_axis_tready  = tready_q;
    assign locked         = locked_q;
    assign frame_done     = frame_done_q;
    assign last_timestamp = last_ts_q;
    assign frames_ok      = frames_ok_q;
    assign sync_err       = sync_err_q;
    assign ts_err         = ts_err_q;
    assign data_err       = data_err_q;

endmodule

// File: tb/tb_axis_frame_checker.sv
// Self-checking bench for axis_frame_checker: randomized frames against a frame-level model.
// Exercises the tlast checks only when AXIS_FRAME_CHECKER_TLAST_CHECK_EN is defined.
module tb_axis_frame_checker;

    localparam int          DW      = 35;
    localparam int          CW      = 4;
    localparam int          CMAX    = (1 << CW) - 1;
    localparam logic [63:0] MAGIC   = 64'hDEADBEEFCAFEBABE;
    localparam logic [63:0] PATTERN = 64'h123456789ABCDEF0;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [63:0]   s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic          s_axis_tlast = 1'b0;
    logic          clear_counters = 1'b0;
    logic          locked;
    logic          frame_done;
    logic [63:0]   last_timestamp;
    logic [CW-1:0] frames_ok, sync_err, ts_err, data_err, tlast_err;

    axis_frame_checker #(
        .DATA_WORDS (DW),
        .MAGIC      (MAGIC),
        .PATTERN    (PATTERN),
        .CNT_W      (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tlast   (s_axis_tlast),
        .clear_counters (clear_counters),
        .locked         (locked),
        .frame_done     (frame_done),
        .last_timestamp (last_timestamp),
        .frames_ok      (frames_ok),
        .sync_err       (sync_err),
        .ts_err         (ts_err),
        .data_err       (data_err),
        .tlast_err      (tlast_err)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int done_cnt   = 0;

    always @(negedge clk) if (frame_done === 1'b1) done_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Frame-level reference model: counts follow from whole frames and stray words.
    int          m_ok, m_sync, m_ts, m_data, m_tlast;
    bit          m_locked, m_ref;
    logic [63:0] m_last;

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    function automatic logic [5*CW-1:0] exp_cnts();
        return {CW'(sat(m_ok)), CW'(sat(m_sync)), CW'(sat(m_ts)), CW'(sat(m_data)),
                CW'(sat(m_tlast))};
    endfunction

    function automatic logic [5*CW-1:0] obs_cnts();
        return {frames_ok, sync_err, ts_err, data_err, tlast_err};
    endfunction

    task automatic model_clear();
        m_ok = 0; m_sync = 0; m_ts = 0; m_data = 0; m_tlast = 0;
    endtask

    task automatic model_reset();
        model_clear();
        m_locked = 1'b0; m_ref = 1'b0; m_last = '0;
    endtask

    task automatic model_frame(input logic [63:0] ts, input int nbad);
        bit err;
        err = 1'b0;
        if (m_ref && ts != m_last + 64'd1) begin
            m_ts++;
            err = 1'b1;
        end
        m_data += nbad;
        if (nbad > 0) err = 1'b1;
        if (!err) m_ok++;
        m_last   = ts;
        m_ref    = 1'b1;
        m_locked = 1'b1;
    endtask

    task automatic model_break();
        if (m_locked) begin
            m_sync++;
            m_locked = 1'b0;
            m_ref    = 1'b0;
        end
    endtask

    function automatic logic [63:0] junk();
        logic [63:0] w;
        do w = {$urandom, $urandom}; while (w == MAGIC);
        return w;
    endfunction

    function automatic logic [DW-1:0] rand_mask();
        logic [DW-1:0] m;
        m = '0;
        for (int i = 0; i < DW; i++) if ($urandom_range(0, 9) == 0) m[i] = 1'b1;
        return m;
    endfunction

    task automatic send_word(input logic [63:0] d, input bit last, input bit gaps, input bit clr);
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                s_axis_tvalid  = 1'b0;
                s_axis_tdata   = {$urandom, $urandom};
                s_axis_tlast   = 1'($urandom);
                clear_counters = 1'b0;
            end
        end
        @(negedge clk);
        s_axis_tvalid  = 1'b1;
        s_axis_tdata   = d;
        s_axis_tlast   = last;
        clear_counters = clr;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            s_axis_tvalid  = 1'b0;
            s_axis_tlast   = 1'b0;
            clear_counters = 1'b0;
        end
        #1;
    endtask

    task automatic send_frame(input logic [63:0] ts, input logic [DW-1:0] mask, input bit zero_bad,
                              input bit gaps, input bit clr_last);
        int          nbad;
        logic [63:0] w;
        nbad = 0;
        send_word(MAGIC, 1'b0, gaps, 1'b0);
        send_word(ts, 1'b0, gaps, 1'b0);
        for (int i = 0; i < DW; i++) begin
            w = PATTERN;
            if (mask[i]) begin
                w = zero_bad ? 64'h0 : PATTERN ^ (64'h1 << $urandom_range(0, 63));
                nbad++;
            end
            send_word(w, i == DW - 1, gaps, clr_last && (i == DW - 1));
        end
        model_frame(ts, nbad);
        if (clr_last) model_clear();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; s_axis_tvalid = 1'b0; clear_counters = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        model_reset();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; s_axis_tvalid = 1'b1; s_axis_tdata = MAGIC;
        repeat (2) @(negedge clk);
        #1;
        compared++;
        if (s_axis_tready !== 1'b0) begin
            mismatched++; $display("FAIL reset_tready got %b want 0", s_axis_tready);
        end
        compared++;
        if ({locked, frame_done} !== 2'b00) begin
            mismatched++; $display("FAIL reset_flags got %b want 00", {locked, frame_done});
        end
        compared++;
        if (last_timestamp !== 64'd0 || obs_cnts() !== '0) begin
            mismatched++;
            $display("FAIL reset_values got ts=%h cnts=%h want 0", last_timestamp, obs_cnts());
        end
        rst = 1'b0;
        @(negedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        compared++;
        if (s_axis_tready !== 1'b1 || locked !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_release got tready=%b locked=%b want 1 0", s_axis_tready, locked);
        end
        model_reset();
    endtask

    task automatic test_clean();
        int d0;
        do_reset();
        d0 = done_cnt;
        for (int t = 5; t <= 7; t++) send_frame(64'(t), '0, 1'b0, 1'b1, 1'b0);
        idle(3);
        compared++;
        if (frames_ok !== CW'(3)) begin
            mismatched++; $display("FAIL clean_frames_ok got %0d want 3", frames_ok);
        end
        compared++;
        if (obs_cnts() !== exp_cnts()) begin
            mismatched++; $display("FAIL clean_cnts got %h want %h", obs_cnts(), exp_cnts());
        end
        compared++;
        if (locked !== 1'b1 || last_timestamp !== 64'd7) begin
            mismatched++;
            $display("FAIL clean_state got locked=%b ts=%0d want 1 7", locked, last_timestamp);
        end
        compared++;
        if (done_cnt - d0 != 3) begin
            mismatched++; $display("FAIL clean_done got %0d want 3", done_cnt - d0);
        end
    endtask

    task automatic test_junk();
        do_reset();
        send_word(junk(), 1'b0, 1'b1, 1'b0);
        send_word(junk(), 1'b0, 1'b1, 1'b0);
        idle(2);
        compared++;
        if (locked !== 1'b0) begin
            mismatched++; $display("FAIL junk_unlocked got %b want 0", locked);
        end
        send_frame(64'd10, '0, 1'b0, 1'b1, 1'b0);
        idle(2);
        compared++;
        if (sync_err !== CW'(0) || frames_ok !== CW'(1)) begin
            mismatched++;
            $display("FAIL junk_cnts got sync=%0d ok=%0d want 0 1", sync_err, frames_ok);
        end
    endtask

    task automatic test_ts_gap();
        do_reset();
        send_frame(64'd10, '0, 1'b0, 1'b1, 1'b0);
        send_frame(64'd12, '0, 1'b0, 1'b1, 1'b0);
        idle(2);
        compared++;
        if (ts_err !== CW'(1) || frames_ok !== CW'(1) || last_timestamp !== 64'd12) begin
            mismatched++;
            $display("FAIL ts_gap got ts_err=%0d ok=%0d last=%0d want 1 1 12", ts_err, frames_ok,
                     last_timestamp);
        end
        send_frame(64'd13, '0, 1'b0, 1'b1, 1'b0);
        idle(2);
        compared++;
        if (frames_ok !== CW'(2) || obs_cnts() !== exp_cnts()) begin
            mismatched++;
            $display("FAIL ts_resume got %h want %h", obs_cnts(), exp_cnts());
        end
    endtask

    task automatic test_data_err();
        logic [DW-1:0] m;
        do_reset();
        m = '0;
        m[17] = 1'b1;
        send_frame(64'd40, m, 1'b1, 1'b1, 1'b0);
        idle(2);
        compared++;
        if (data_err !== CW'(1) || locked !== 1'b1 || frames_ok !== CW'(0)) begin
            mismatched++;
            $display("FAIL data_word17 got derr=%0d locked=%b ok=%0d want 1 1 0", data_err, locked,
                     frames_ok);
        end
        for (int k = 0; k < 3; k++) send_frame(m_last + 64'd1, rand_mask(), 1'b0, 1'b1, 1'b0);
        idle(2);
        compared++;
        if (obs_cnts() !== exp_cnts()) begin
            mismatched++; $display("FAIL data_random got %h want %h", obs_cnts(), exp_cnts());
        end
    endtask

    task automatic test_sync();
        logic [63:0] r;
        do_reset();
        r = {$urandom, $urandom};
        send_frame(r, '0, 1'b0, 1'b1, 1'b0);
        send_word(junk(), 1'b0, 1'b1, 1'b0);
        model_break();
        idle(2);
        compared++;
        if (sync_err !== CW'(1) || locked !== 1'b0) begin
            mismatched++;
            $display("FAIL sync_break got sync=%0d locked=%b want 1 0", sync_err, locked);
        end
        send_frame(r + 64'd7, '0, 1'b0, 1'b1, 1'b0);
        idle(2);
        compared++;
        if (locked !== 1'b1 || ts_err !== CW'(0) || frames_ok !== CW'(2)) begin
            mismatched++;
            $display("FAIL sync_relock got locked=%b ts_err=%0d ok=%0d want 1 0 2", locked, ts_err,
                     frames_ok);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        send_frame('1, '0, 1'b0, 1'b1, 1'b0);
        send_frame(64'd0, '0, 1'b0, 1'b1, 1'b0);
        idle(2);
        compared++;
        if (ts_err !== CW'(0) || frames_ok !== CW'(2) || last_timestamp !== 64'd0) begin
            mismatched++;
            $display("FAIL ts_wrap got ts_err=%0d ok=%0d last=%h want 0 2 0", ts_err, frames_ok,
                     last_timestamp);
        end
    endtask

    task automatic test_clear();
        int d0;
        do_reset();
        d0 = done_cnt;
        send_frame(64'd20, '0, 1'b0, 1'b1, 1'b0);
        send_frame(64'd21, '0, 1'b0, 1'b1, 1'b1);
        idle(2);
        compared++;
        if (frames_ok !== CW'(0) || obs_cnts() !== exp_cnts()) begin
            mismatched++; $display("FAIL clear_priority got %h want %h", obs_cnts(), exp_cnts());
        end
        compared++;
        if (last_timestamp !== 64'd21 || locked !== 1'b1 || done_cnt - d0 != 2) begin
            mismatched++;
            $display("FAIL clear_state got last=%0d locked=%b done=%0d want 21 1 2",
                     last_timestamp, locked, done_cnt - d0);
        end
        send_frame(64'd22, '0, 1'b0, 1'b1, 1'b0);
        idle(2);
        compared++;
        if (frames_ok !== CW'(1) || ts_err !== CW'(0)) begin
            mismatched++;
            $display("FAIL clear_after got ok=%0d ts_err=%0d want 1 0", frames_ok, ts_err);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        send_frame(64'd1, '1, 1'b0, 1'b0, 1'b0);
        idle(2);
        compared++;
        if (data_err !== CW'(CMAX) || frames_ok !== CW'(0)) begin
            mismatched++;
            $display("FAIL saturate got derr=%0d ok=%0d want %0d 0", data_err, frames_ok, CMAX);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] base;
        int          d0;
        do_reset();
        base = {$urandom, $urandom};
        d0   = done_cnt;
        for (int k = 0; k < 4; k++) send_frame(base + 64'(k), '0, 1'b0, 1'b0, 1'b0);
        idle(3);
        compared++;
        if (done_cnt - d0 != 4 || obs_cnts() !== exp_cnts()) begin
            mismatched++;
            $display("FAIL b2b got done=%0d cnts=%h want 4 %h", done_cnt - d0, obs_cnts(),
                     exp_cnts());
        end
        compared++;
        if (last_timestamp !== base + 64'd3 || frame_done !== 1'b0) begin
            mismatched++;
            $display("FAIL b2b_last got %h done=%b want %h 0", last_timestamp, frame_done,
                     base + 64'd3);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_frame(64'd100, '0, 1'b0, 1'b1, 1'b0);
        send_word(MAGIC, 1'b0, 1'b0, 1'b0);
        send_word(64'd101, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) send_word(PATTERN, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1; s_axis_tdata = PATTERN; s_axis_tvalid = 1'b1;
        @(negedge clk);
        #1;
        compared++;
        if (locked !== 1'b0 || last_timestamp !== 64'd0 || obs_cnts() !== '0 ||
            s_axis_tready !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_mid got locked=%b last=%h cnts=%h tready=%b want 0 0 0 0",
                     locked, last_timestamp, obs_cnts(), s_axis_tready);
        end
        rst = 1'b0; s_axis_tvalid = 1'b0;
        @(negedge clk);
        model_reset();
        send_frame(64'd500, '0, 1'b0, 1'b1, 1'b0);
        idle(2);
        compared++;
        if (frames_ok !== CW'(1) || ts_err !== CW'(0) || last_timestamp !== 64'd500) begin
            mismatched++;
            $display("FAIL reset_mid_after got ok=%0d ts_err=%0d last=%0d want 1 0 500", frames_ok,
                     ts_err, last_timestamp);
        end
    endtask

    task automatic test_random();
        logic [63:0] ts;
        do_reset();
        for (int k = 0; k < 15; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                send_word(junk(), 1'b0, 1'b1, 1'b0);
                model_break();
            end else begin
                ts = ($urandom_range(0, 1) == 1) ? m_last + 64'd1 : {$urandom, $urandom};
                send_frame(ts, ($urandom_range(0, 2) == 0) ? rand_mask() : '0, 1'b0, 1'b1, 1'b0);
            end
            idle(2);
            compared++;
            if (obs_cnts() !== exp_cnts()) begin
                mismatched++;
                $display("FAIL random_cnts[%0d] got %h want %h", k, obs_cnts(), exp_cnts());
            end
            compared++;
            if (locked !== m_locked || last_timestamp !== m_last) begin
                mismatched++;
                $display("FAIL random_state[%0d] got locked=%b last=%h want %b %h", k, locked,
                         last_timestamp, m_locked, m_last);
            end
        end
    endtask

`ifdef AXIS_FRAME_CHECKER_TLAST_CHECK_EN
    task automatic test_tlast();
        do_reset();
        send_frame(64'd30, '0, 1'b0, 1'b1, 1'b0);
        send_word(MAGIC, 1'b0, 1'b1, 1'b0);
        send_word(64'd31, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) send_word(PATTERN, i == 19, 1'b1, 1'b0);
        m_tlast++; m_locked = 1'b0; m_ref = 1'b0;
        idle(2);
        compared++;
        if (tlast_err !== CW'(1) || locked !== 1'b0) begin
            mismatched++;
            $display("FAIL tlast_early got terr=%0d locked=%b want 1 0", tlast_err, locked);
        end
        send_frame(64'd40, '0, 1'b0, 1'b1, 1'b0);
        idle(2);
        compared++;
        if (obs_cnts() !== exp_cnts() || frames_ok !== CW'(2)) begin
            mismatched++; $display("FAIL tlast_recover got %h want %h", obs_cnts(), exp_cnts());
        end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_clean();
        test_junk();
        test_ts_gap();
        test_data_err();
        test_sync();
        test_wrap();
        test_clear();
        test_saturate();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef AXIS_FRAME_CHECKER_TLAST_CHECK_EN
        test_tlast();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
